// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_pkg
//  Description : Shared widths, mode encodings and command record for the
//                shift/rotate pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

  localparam int DATA_W  = 16;
  localparam int SHAMT_W = 4;

  localparam logic [1:0] SH_LOGIC = 2'b00;
  localparam logic [1:0] SH_ARITH = 2'b01;
  localparam logic [1:0] SH_ROT   = 2'b10;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [SHAMT_W-1:0] shamt;
    logic               lr;
    logic [1:0]         mode;
  } shift_cmd_t;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shift_core_16.sv
`default_nettype none
// ============================================================================
//  Module      : shift_core_16
//  Description : Combinational 16-bit log-stage barrel (1/2/4/8) providing
//                logical shift, arithmetic shift and rotate.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_core_16
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0]  i_data,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  logic               i_lr,
  input  logic [1:0]         i_mode,
  output logic [DATA_W-1:0]  o_result
);

  // One barrel layer: moves by a fixed amount when enabled. Rotate wraps the
  // bits that leave one end; arithmetic right fills with the operand sign.
  function automatic logic [DATA_W-1:0] barrel_step(
    input logic [DATA_W-1:0] x,
    input logic              en,
    input logic              lr,
    input logic              rot,
    input logic              sign,
    input int unsigned       amt
  );
    logic [DATA_W-1:0] shl;
    logic [DATA_W-1:0] shr;
    logic [DATA_W-1:0] wrap_l;
    logic [DATA_W-1:0] wrap_r;
    logic [DATA_W-1:0] fill_r;
    shl    = x << amt;
    shr    = x >> amt;
    wrap_l = rot ? (x >> (DATA_W - amt)) : '0;
    wrap_r = rot ? (x << (DATA_W - amt)) : '0;
    fill_r = sign ? ~({DATA_W{1'b1}} >> amt) : '0;
    if (!en)
      barrel_step = x;
    else if (lr)
      barrel_step = shl | wrap_l;
    else
      barrel_step = shr | wrap_r | fill_r;
  endfunction

  logic              w_rot;
  logic              w_sign;
  logic [DATA_W-1:0] w_st1;
  logic [DATA_W-1:0] w_st2;
  logic [DATA_W-1:0] w_st4;
  logic [DATA_W-1:0] w_st8;

  // Reserved mode 11 falls through to the logical path.
  assign w_rot  = (i_mode == SH_ROT);
  assign w_sign = (i_mode == SH_ARITH) && i_data[DATA_W-1];

  assign w_st1 = barrel_step(i_data, i_shamt[0], i_lr, w_rot, w_sign, 1);
  assign w_st2 = barrel_step(w_st1,  i_shamt[1], i_lr, w_rot, w_sign, 2);
  assign w_st4 = barrel_step(w_st2,  i_shamt[2], i_lr, w_rot, w_sign, 4);
  assign w_st8 = barrel_step(w_st4,  i_shamt[3], i_lr, w_rot, w_sign, 8);

  assign o_result = w_st8;

endmodule : shift_core_16
`default_nettype wire

// File: rtl/shift_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : shift_pipe_ctrl
//  Description : Two-stage valid/ready shift/rotate pipeline with a count of
//                results accepted downstream.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_pipe_ctrl
  import shift_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic               in_lr,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_zero,
  output logic [CNT_W-1:0]   out_count
);

  shift_cmd_t        r_s1_cmd;
  logic              r_s1_valid;
  logic              r_s2_valid;
  logic [DATA_W-1:0] r_s2_data;
  logic              r_s2_zero;
  logic [CNT_W-1:0]  r_count;

  logic              w_s2_free;
  logic              w_s1_adv;
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic [DATA_W-1:0] w_core_result;

  // in_ready depends combinationally on out_ready so a full pipe can still
  // accept when both stages drain together.
  assign w_s2_free  = !r_s2_valid || out_ready;
  assign w_s1_adv   = r_s1_valid && w_s2_free;
  assign in_ready   = !r_s1_valid || w_s2_free;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_s2_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_cmd   <= '0;
    end else if (w_in_xfer) begin
      r_s1_valid     <= 1'b1;
      r_s1_cmd.data  <= in_data;
      r_s1_cmd.shamt <= in_shamt;
      r_s1_cmd.lr    <= in_lr;
      r_s1_cmd.mode  <= in_mode;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  shift_core_16 u_core (
    .i_data   (r_s1_cmd.data),
    .i_shamt  (r_s1_cmd.shamt),
    .i_lr     (r_s1_cmd.lr),
    .i_mode   (r_s1_cmd.mode),
    .o_result (w_core_result)
  );

  // Result registers keep their last value on drain; only valid is cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_zero  <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_valid <= 1'b1;
      r_s2_data  <= w_core_result;
      r_s2_zero  <= (w_core_result == '0);
    end else if (w_out_xfer) begin
      r_s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_count <= '0;
    else if (w_out_xfer)
      r_count <= r_count + 1'b1;
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;
  assign out_zero  = r_s2_zero;
  assign out_count = r_count;

endmodule : shift_pipe_ctrl
`default_nettype wire

// File: tb/tb_shift_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_pipe_ctrl
//  Description : Directed self-checking bench for shift_pipe_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_pipe_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_shamt;
  logic        in_lr;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_zero;
  logic [7:0]  out_count;

  int errors = 0;
  int checks = 0;
  int exp_count = 0;

  shift_pipe_ctrl #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_lr     (in_lr),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk); #1;
    rst_n     = 1'b1;
    exp_count = 0;
  endtask

  // Single command through an empty pipe with out_ready held high.
  task automatic run_one(input string tag, input logic [15:0] d, input logic [3:0] sh,
                         input logic lr, input logic [1:0] md, input logic [15:0] exp);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    in_shamt  = sh;
    in_lr     = lr;
    in_mode   = md;
    #1;
    chk({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_lat1_valid"}, out_valid, 0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_data"}, out_data, exp);
    chk({tag, "_zero"}, out_zero, (exp == 16'h0000));
    exp_count++;
    @(posedge clk); #1;
    chk({tag, "_drained"}, out_valid, 0);
    chk({tag, "_count"}, out_count, exp_count);
  endtask

  initial begin
    int  idx;
    int  nout;
    logic acc;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_lr     = 1'b0;
    in_mode   = 2'b00;
    out_ready = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data,  16'h0000);
    chk("rst_out_zero",  out_zero,  0);
    chk("rst_out_count", out_count, 0);
    chk("rst_in_ready",  in_ready,  1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_one("lsl1",   16'h8001, 4'd1,  1'b1, 2'b00, 16'h0002);
    run_one("lsr1",   16'h8001, 4'd1,  1'b0, 2'b00, 16'h4000);
    run_one("lsr15",  16'h8000, 4'd15, 1'b0, 2'b00, 16'h0001);
    run_one("asr4n",  16'h8001, 4'd4,  1'b0, 2'b01, 16'hF800);
    run_one("asr4p",  16'h7FF0, 4'd4,  1'b0, 2'b01, 16'h07FF);
    run_one("asr15",  16'h8000, 4'd15, 1'b0, 2'b01, 16'hFFFF);
    run_one("asl1",   16'h8001, 4'd1,  1'b1, 2'b01, 16'h0002);
    run_one("rol4",   16'h1234, 4'd4,  1'b1, 2'b10, 16'h2341);
    run_one("ror1",   16'h0001, 4'd1,  1'b0, 2'b10, 16'h8000);
    run_one("ror15",  16'h8001, 4'd15, 1'b0, 2'b10, 16'h0003);
    run_one("rol8",   16'hABCD, 4'd8,  1'b1, 2'b10, 16'hCDAB);
    run_one("rot0",   16'hABCD, 4'd0,  1'b1, 2'b10, 16'hABCD);
    run_one("zero",   16'h0000, 4'd3,  1'b0, 2'b01, 16'h0000);
    run_one("rotz",   16'h0000, 4'd5,  1'b1, 2'b10, 16'h0000);
    run_one("mode11", 16'h8001, 4'd1,  1'b0, 2'b11, 16'h4000);

    // Backpressure: five commands (n+1)<<4 with downstream stalled 4 cycles.
    do_reset();
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      in_data  = 16'(idx + 1);
      in_shamt = 4'd4;
      in_lr    = 1'b1;
      in_mode  = 2'b00;
      #1;
      acc = in_ready;
      if (c >= 2) begin
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_valid_held",   out_valid, 1);
        chk("bp_data_held",    out_data, 16'h0010);
      end
      @(posedge clk); #1;
      if (acc) idx++;
    end
    chk("bp_accepts", idx, 2);

    out_ready = 1'b1;
    nout = 0;
    for (int c = 0; c < 12 && nout < 5; c++) begin
      in_valid = (idx < 5);
      in_data  = 16'(idx + 1);
      #1;
      acc = in_valid && in_ready;
      if (out_valid) begin
        chk($sformatf("bp_out%0d", nout), out_data, 32'(16'h0010 * (nout + 1)));
        nout++;
      end
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("bp_all_out", nout, 5);
    chk("bp_count", out_count, 5);

    // Back-to-back: 20 commands (c+1)<<1 in reserved mode, no gaps after fill.
    do_reset();
    out_ready = 1'b1;
    in_shamt  = 4'd1;
    in_lr     = 1'b1;
    in_mode   = 2'b11;
    for (int c = 0; c < 22; c++) begin
      in_valid = (c < 20);
      in_data  = 16'(c + 1);
      #1;
      chk($sformatf("b2b_valid%0d", c), out_valid, (c >= 2));
      if (c >= 2)
        chk($sformatf("b2b_data%0d", c), out_data, 32'(2 * (c - 1)));
      @(posedge clk); #1;
    end
    chk("b2b_count", out_count, 20);

    // 256 more transfers wrap the 8-bit counter back to 20.
    in_valid = 1'b1;
    for (int c = 0; c < 256; c++) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("wrap_drained", out_valid, 0);
    chk("wrap_count", out_count, 20);

    // Reset with both stages full.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h5555;
    in_mode   = 2'b00;
    repeat (2) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("full_valid",    out_valid, 1);
    chk("full_in_ready", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_valid",    out_valid, 0);
    chk("arst_count",    out_count, 0);
    chk("arst_data",     out_data, 16'h0000);
    chk("arst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    exp_count = 0;
    run_one("post_rst", 16'h00F0, 4'd4, 1'b0, 2'b00, 16'h000F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_shift_pipe_ctrl
`default_nettype wire

// File: doc/shift_pipe_ctrl.md
Name: shift_pipe_ctrl

Overview:
- Two-stage pipelined shift/rotate unit with a valid/ready handshake on input and output.
- Sits between the operand/command source and the result writeback path.
- Stage 1 registers the command. Stage 2 computes the result in a combinational 16-bit shift core and registers it.
- Provides logical shift, arithmetic shift and rotate, with backpressure and a completed-operation counter.

Parameters:
- CNT_W, 8, width of the completed-operation counter out_count.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  command present on in_* this cycle.
- in_ready  output  1  block accepts the command this cycle.
- in_data  input  16  operand.
- in_shamt  input  4  shift/rotate amount, 0..15.
- in_lr  input  1  direction: 1 = left, 0 = right.
- in_mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved (executes as logical).
- out_valid  output  1  result present on out_data.
- out_ready  input  1  downstream accepts the result this cycle.
- out_data  output  16  shifted/rotated result.
- out_zero  output  1  out_data == 0, valid while out_valid = 1.
- out_count  output  CNT_W  number of results accepted downstream, wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n low, asynchronous):
  - s1_valid = 0, s2_valid = 0.
  - out_valid = 0, out_data = 0x0000, out_zero = 0, out_count = 0.
  - in_ready is combinational and evaluates to 1 while in reset.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - out_data and out_zero are held stable while out_valid && !out_ready.
- Stall logic:
  - s2_free = !s2_valid || out_ready.
  - s1_adv = s1_valid && s2_free.
  - in_ready = !s1_valid || s2_free. This is a combinational path from out_ready, which is permitted.
- Stage 1:
  - On input transfer, capture data, shamt, lr and mode; s1_valid is set to 1.
  - If s1_adv occurs without a new input transfer, s1_valid is cleared to 0.
- Stage 2:
  - On s1_adv, s2 data <= core(s1 fields) and s2_valid <= 1.
  - On output transfer without s1_adv, s2_valid <= 0.
  - out_valid = s2_valid.
- Latency and throughput:
  - Latency is 2 cycles: a command accepted at edge N is visible on out_data after edge N+1 (out_valid high in cycle N+1..N+2).
  - Throughput is 1 result per cycle while out_ready = 1.
- Core arithmetic (all shift amounts 0..15; shamt 0 passes data through unchanged in every mode):
  - Logical left: zero-fill from the LSB.
  - Logical right: zero-fill from the MSB.
  - Arithmetic left: identical to logical left.
  - Arithmetic right: fill with bit 15 of the operand.
  - Rotate left: bits leaving the MSB enter at the LSB.
  - Rotate right: bits leaving the LSB enter at the MSB.
  - Mode 11 behaves exactly as mode 00.
- out_zero:
  - Registered with out_data.
  - Reflects the result of the rotate modes as well.
- out_count:
  - Increments by 1 on each output transfer.
  - Wraps from 2^CNT_W-1 to 0.
- Simultaneous events:
  - Input and output transfer in the same cycle with both stages full: both stages advance and no command is lost or duplicated.
  - Pipeline full and out_ready = 0: in_ready = 0 and all state is held.
- Reset mid-operation: in-flight commands are discarded. The first command after rst_n deasserts follows the normal 2-cycle latency.
- No X propagation: unused stage registers hold their last value; out_data is not cleared on drain.

Decomposition:
- Shared package shift_pkg:
  - mode constants SH_LOGIC = 2'b00, SH_ARITH = 2'b01, SH_ROT = 2'b10.
  - DATA_W = 16, SHAMT_W = 4.
  - Packed command struct {data, shamt, lr, mode}.
- Sub-module shift_core_16:
  - Purely combinational log-stage barrel (stages 1/2/4/8) implementing the three modes.
  - Instanced once in stage 2.
  - Unit-testable standalone.

Test Plan:
- Logical: 0x8001, shamt 1, lr 1, mode 00 -> 0x0002. Then 0x8001, shamt 1, lr 0 -> 0x4000. Each appears 2 cycles after acceptance.
- Arithmetic right: 0x8001, shamt 4, mode 01 -> 0xF800. Then 0x7FF0, shamt 4, mode 01 -> 0x07FF. Then 0x8000, shamt 15, mode 01 -> 0xFFFF.
- Rotate:
  - 0x1234 rotated left 4 (mode 10, lr 1) -> 0x2341.
  - 0x0001 rotated right 1 (lr 0) -> 0x8000.
  - 0xABCD with shamt 0 -> 0xABCD.
  - 0x0000 in any mode -> out_zero = 1.
- Backpressure:
  - Stream 5 commands with out_ready = 0 for 4 cycles: in_ready drops after 2 accepts and out_data holds.
  - Release out_ready: all 5 results emerge in order, and out_count = 5.
- Back-to-back: in_valid = 1 and out_ready = 1 for 20 cycles -> one result per cycle after 2-cycle fill, with no gaps.
- Reset mid-stream: assert rst_n low asynchronously with both stages full -> out_valid = 0 and out_count = 0 immediately. The next command after release returns its result 2 cycles later.
